core_run_ctrl: RTL and testbench
================================

// Module: core_run_ctrl
// PURPOSE
// - Run-control and program-loader unit placed between the host interface and a single-issue core.
// - Streams program words into instruction memory over a valid/ready handshake.
// - Replaces clock gating with a core clock-enable. Adds single-step, breakpoint, cycle counting,
//   change-detected stdout capture and a sticky command error.
// PARAMETERS
// - ADDR_W   6   instruction-memory word-address width; depth = 2**ADDR_W
// - DATA_W   32  instruction / stdout word width
// - PC_W     32  core PC width; PC is a byte address, word index = pc[ADDR_W+1:2]
// - CYCLE_W  32  run-cycle counter width
// PORTS
// - clk          in   1        single clock
// - reset        in   1        synchronous, active-low
// - cmd_valid    in   1        command strobe (cmd_ready is constant 1)
// - cmd_ready    out  1        tied 1; unsupported commands are dropped and flagged
// - cmd_op       in   3        0 NOP, 1 LOAD, 2 RUN, 3 STEP, 4 HALT, 5 CLEAR, 6 SETBP, 7 CLRBP
// - cmd_arg      in   PC_W     LOAD: word count; SETBP: breakpoint PC
// - ld_valid     in   1        program word valid
// - ld_ready     out  1        high only in LOAD
// - ld_data      in   DATA_W   program word
// - imem_we      out  1        instruction-memory write enable (= ld_valid & ld_ready)
// - imem_waddr   out  ADDR_W   write word address
// - imem_wdata   out  DATA_W   = ld_data
// - core_en      out  1        core clock enable (combinational)
// - core_reset   out  1        active-low core reset
// - core_pc      in   PC_W     core program counter
// - core_stdout  in   DATA_W   core stdout register
// - out_valid    out  1        one-cycle strobe; new stdout value
// - out_data     out  DATA_W   captured stdout value
// - state        out  3        0 IDLE, 1 LOAD, 2 RUN, 3 STEP, 4 HALT
// - cycles       out  CYCLE_W  count of cycles with core_en=1; saturates at all-ones
// - err          out  1        sticky illegal-command flag
// BEHAVIOUR
// - Reset (reset=0 at a clk edge):
//   - state=IDLE, cycles=0, err=0, out_valid=0, out_data=0, bp disabled, waddr=0.
//   - core_reset=0 for every cycle reset is low, then stays 0 until the first RUN or STEP.
// - IDLE:
//   - LOAD: n = min(cmd_arg, 2**ADDR_W). n=0 stays in IDLE. Otherwise go to LOAD with waddr=0, remaining=n.
//   - RUN or STEP: release core_reset and go to RUN or STEP.
//   - HALT: NOP. Other commands follow the common rules below.
// - LOAD:
//   - Each ld_valid&ld_ready cycle writes ld_data to waddr, increments waddr and decrements remaining.
//   - The last word returns to IDLE on the next edge. waddr never wraps.
//   - HALT aborts to IDLE. Words already written stay written.
//   - Any other command except NOP or SETBP/CLRBP sets err.
//   - core_reset=0 and core_en=0 throughout LOAD.
// - RUN:
//   - core_en = !(bp_en && core_pc==bp_addr && !bp_skip).
//   - A breakpoint hit holds core_en=0 in that cycle and goes to HALT next edge; the hit instruction is not executed.
//   - HALT goes to HALT next edge; core_en stays 1 in the command cycle.
//   - LOAD or STEP sets err and is dropped.
// - STEP: core_en=1 for exactly one cycle, ignoring the breakpoint, then HALT.
// - HALT:
//   - RUN sets bp_skip for the first RUN cycle so execution leaves the breakpoint PC.
//   - STEP executes one instruction. LOAD goes to LOAD; the core stays held in reset.
// - Common rules, any state:
//   - CLEAR: go to IDLE and clear cycles, err and bp_skip. Assert core_reset=0; it stays 0 until the next RUN or STEP.
//   - SETBP: latch bp_addr=cmd_arg and set bp_en=1. CLRBP: bp_en=0.
//   - NOP: no effect.
// - Stdout: a core_stdout value that differs from the previous cycle's value while core_reset=1 sets
//   out_valid=1 and out_data=core_stdout on the next edge (latency 1, one-cycle strobe).
// - Priority in one cycle: reset > CLEAR > breakpoint hit > other command.
// STRUCTURE
// - Package core_ctrl_pkg holds these typedefs:
//   - cmd_op_e (3 bit, values above)
//   - run_state_e (3 bit, values above)
// - One sub-module: core_bp_match (comparator plus bp_en/bp_addr/bp_skip registers) producing bp_hit.
// - Everything else (FSM, load counter, cycle counter, stdout capture) lives in core_run_ctrl.
// TESTING
// - LOAD arg=3, words A,B,C with a 1-cycle ld_valid gap -> imem writes addr 0,1,2; state IDLE after the 3rd word; ld_ready=0 afterwards.
// - LOAD arg=100 with ADDR_W=6 -> exactly 64 writes, addr 0..63, no wrap; HALT after 10 words -> IDLE, 10 writes only.
// - SETBP 0x10, RUN, core_pc reaches 0x10 -> core_en=0 that cycle, state HALT next; RUN -> core_en=1 at 0x10.
// - STEP from HALT x3 -> exactly 3 core_en pulses; cycles increments by 3.
// - core_stdout 0->0x41->0x41->0x42 -> two out_valid strobes, each one cycle late, data 0x41 then 0x42.
// - STEP during RUN -> err=1, state stays RUN; CLEAR -> err=0, cycles=0, core_reset=0; reset mid-LOAD -> IDLE, imem_we=0.

Source files
------------

// File: rtl/core_ctrl_pkg.sv
// Shared command and run-state encodings for the core run-control unit.
package core_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_LOAD  = 3'd1,
        OP_RUN   = 3'd2,
        OP_STEP  = 3'd3,
        OP_HALT  = 3'd4,
        OP_CLEAR = 3'd5,
        OP_SETBP = 3'd6,
        OP_CLRBP = 3'd7
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_STEP = 3'd3,
        ST_HALT = 3'd4
    } run_state_e;

endpackage

// File: rtl/core_bp_match.sv
// Single hardware breakpoint: address/enable registers, a one-shot skip used
// to resume past the breakpoint PC, and the PC comparator.
module core_bp_match #(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            set_bp,
    input  logic            clr_bp,
    input  logic [PC_W-1:0] bp_arg,
    input  logic            skip_set,
    input  logic            skip_clr,
    input  logic [PC_W-1:0] pc,
    output logic            bp_hit
);

    logic            bp_en_q, bp_en_d;
    logic [PC_W-1:0] bp_addr_q, bp_addr_d;
    logic            bp_skip_q, bp_skip_d;

    // Next values: SETBP wins over CLRBP; a clear of the skip wins over a set
    always_comb begin
        bp_en_d   = bp_en_q;
        bp_addr_d = bp_addr_q;
        bp_skip_d = bp_skip_q;
        if (set_bp) begin
            bp_en_d   = 1'b1;
            bp_addr_d = bp_arg;
        end else if (clr_bp) begin
            bp_en_d = 1'b0;
        end
        if (skip_clr)      bp_skip_d = 1'b0;
        else if (skip_set) bp_skip_d = 1'b1;
    end

    // Breakpoint registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            bp_en_q   <= 1'b0;
            bp_addr_q <= '0;
            bp_skip_q <= 1'b0;
        end else begin
            bp_en_q   <= bp_en_d;
            bp_addr_q <= bp_addr_d;
            bp_skip_q <= bp_skip_d;
        end
    end

    assign bp_hit = bp_en_q && (pc == bp_addr_q) && !bp_skip_q;

endmodule

// File: rtl/core_run_ctrl.sv
// Run-control / program loader: streams program words into instruction
// memory and drives core clock-enable and reset with run/step/breakpoint
// control, cycle counting and stdout change capture.
module core_run_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 32,
    parameter int PC_W    = 32,
    parameter int CYCLE_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_op,
    input  logic [PC_W-1:0]    cmd_arg,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic [DATA_W-1:0]  ld_data,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_waddr,
    output logic [DATA_W-1:0]  imem_wdata,
    output logic               core_en,
    output logic               core_reset,
    input  logic [PC_W-1:0]    core_pc,
    input  logic [DATA_W-1:0]  core_stdout,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic [2:0]         state,
    output logic [CYCLE_W-1:0] cycles,
    output logic               err
);

    localparam int DEPTH = 1 << ADDR_W;

    run_state_e         state_q, state_d;
    logic [ADDR_W-1:0]  waddr_q, waddr_d;
    logic [ADDR_W:0]    remaining_q, remaining_d;
    logic               err_q, err_d;
    logic               core_rst_q, core_rst_d;
    logic [CYCLE_W-1:0] cycles_q, cycles_d;
    logic [DATA_W-1:0]  prev_q, prev_d;
    logic               out_valid_q, out_valid_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;

    cmd_op_e         op;
    logic            is_clear, ld_fire, last_word, bp_hit, skip_clr;
    logic            err_set, skip_set, ld_start, rst_release, rst_assert;
    logic [ADDR_W:0] load_n;

    assign op        = cmd_valid ? cmd_op_e'(cmd_op) : OP_NOP;
    assign is_clear  = (op == OP_CLEAR);
    assign cmd_ready = 1'b1;
    assign ld_fire   = ld_valid && ld_ready;
    assign last_word = ld_fire && (remaining_q == (ADDR_W+1)'(1));
    assign skip_clr  = is_clear || (state_q == ST_RUN);

    // Requested word count clipped to the memory depth
    always_comb begin
        load_n = cmd_arg[ADDR_W:0];
        if (cmd_arg >= PC_W'(DEPTH)) load_n = (ADDR_W+1)'(DEPTH);
    end

    core_bp_match #(.PC_W(PC_W)) u_bp (
        .clk      (clk),
        .reset    (reset),
        .set_bp   (op == OP_SETBP),
        .clr_bp   (op == OP_CLRBP),
        .bp_arg   (cmd_arg),
        .skip_set (skip_set),
        .skip_clr (skip_clr),
        .pc       (core_pc),
        .bp_hit   (bp_hit)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state plus side-effect strobes; CLEAR overrides everything
    always_comb begin
        state_d     = state_q;
        err_set     = 1'b0;
        skip_set    = 1'b0;
        ld_start    = 1'b0;
        rst_release = 1'b0;
        rst_assert  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                case (op)
                    OP_LOAD: if (load_n != '0) begin state_d = ST_LOAD; ld_start = 1'b1; end
                    OP_RUN:  begin state_d = ST_RUN;  rst_release = 1'b1; end
                    OP_STEP: begin state_d = ST_STEP; rst_release = 1'b1; end
                    default: ;
                endcase
            end
            ST_LOAD: begin
                if (last_word) state_d = ST_IDLE;
                case (op)
                    OP_HALT: state_d = ST_IDLE;
                    OP_LOAD, OP_RUN, OP_STEP: err_set = 1'b1;
                    default: ;
                endcase
            end
            ST_RUN: begin
                if (bp_hit) state_d = ST_HALT;
                else begin
                    case (op)
                        OP_HALT: state_d = ST_HALT;
                        OP_LOAD, OP_STEP: err_set = 1'b1;
                        default: ;
                    endcase
                end
            end
            ST_STEP: begin
                state_d = ST_HALT;
                if (op == OP_LOAD || op == OP_RUN || op == OP_STEP) err_set = 1'b1;
            end
            ST_HALT: begin
                case (op)
                    OP_RUN:  begin state_d = ST_RUN;  skip_set = 1'b1; rst_release = 1'b1; end
                    OP_STEP: begin state_d = ST_STEP; rst_release = 1'b1; end
                    OP_LOAD: if (load_n != '0) begin
                        state_d = ST_LOAD; ld_start = 1'b1; rst_assert = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: state_d = ST_IDLE;
        endcase
        if (is_clear) begin
            state_d     = ST_IDLE;
            err_set     = 1'b0;
            skip_set    = 1'b0;
            ld_start    = 1'b0;
            rst_release = 1'b0;
        end
    end

    // FSM outputs: loader handshake and core clock enable
    always_comb begin
        ld_ready = (state_q == ST_LOAD);
        core_en  = ((state_q == ST_RUN) && !bp_hit) || (state_q == ST_STEP);
    end

    // Datapath next values: load pointer, error flag, core reset, counter, stdout
    always_comb begin
        waddr_d     = waddr_q;
        remaining_d = remaining_q;
        if (ld_start) begin
            waddr_d     = '0;
            remaining_d = load_n;
        end else if (ld_fire) begin
            remaining_d = remaining_q - 1'b1;
            if (!last_word) waddr_d = waddr_q + 1'b1;
        end
        err_d = is_clear ? 1'b0 : (err_q || err_set);
        core_rst_d = core_rst_q;
        if (is_clear || rst_assert) core_rst_d = 1'b0;
        else if (rst_release)       core_rst_d = 1'b1;
        cycles_d = cycles_q;
        if (is_clear)                          cycles_d = '0;
        else if (core_en && cycles_q != '1)    cycles_d = cycles_q + 1'b1;
        prev_d      = core_stdout;
        out_valid_d = core_reset && (core_stdout != prev_q);
        out_data_d  = out_valid_d ? core_stdout : out_data_q;
    end

    // Datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            waddr_q     <= '0;
            remaining_q <= '0;
            err_q       <= 1'b0;
            core_rst_q  <= 1'b0;
            cycles_q    <= '0;
            prev_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            waddr_q     <= waddr_d;
            remaining_q <= remaining_d;
            err_q       <= err_d;
            core_rst_q  <= core_rst_d;
            cycles_q    <= cycles_d;
            prev_q      <= prev_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign imem_we    = ld_fire;
    assign imem_waddr = waddr_q;
    assign imem_wdata = ld_data;
    assign core_reset = core_rst_q && reset;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign state      = state_q;
    assign cycles     = cycles_q;
    assign err        = err_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Bench for core_run_ctrl: scoreboard queues for imem writes and stdout
// strobes plus per-scenario inline checks.
module tb_core_run_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_arg;
    logic        ld_valid, ld_ready;
    logic [31:0] ld_data;
    logic        imem_we;
    logic [5:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        core_en, core_reset;
    logic [31:0] core_pc, core_stdout;
    logic        out_valid;
    logic [31:0] out_data;
    logic [2:0]  state;
    logic [31:0] cycles;
    logic        err;

    int checks = 0;
    int errors = 0;
    bit mon_en = 0;
    logic [37:0] wq[$];
    logic [31:0] oq[$];

    always #5 clk = ~clk;

    core_run_ctrl dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .core_en(core_en), .core_reset(core_reset), .core_pc(core_pc), .core_stdout(core_stdout),
        .out_valid(out_valid), .out_data(out_data), .state(state), .cycles(cycles), .err(err)
    );

    // Scoreboard monitor: every imem write and stdout strobe must match the queue head
    always @(negedge clk) begin
        if (mon_en) begin
            if (imem_we === 1'b1) begin
                checks++;
                if (wq.size() == 0) begin
                    errors++;
                    $display("FAIL imem_write unexpected: addr=%0d data=%h", imem_waddr, imem_wdata);
                end else begin
                    logic [37:0] e;
                    e = wq.pop_front();
                    if ({imem_waddr, imem_wdata} !== e) begin
                        errors++;
                        $display("FAIL imem_write: got addr=%0d data=%h expected addr=%0d data=%h",
                                 imem_waddr, imem_wdata, e[37:32], e[31:0]);
                    end
                end
            end
            if (out_valid === 1'b1) begin
                checks++;
                if (oq.size() == 0) begin
                    errors++;
                    $display("FAIL stdout_strobe unexpected: data=%h", out_data);
                end else begin
                    logic [31:0] e;
                    e = oq.pop_front();
                    if (out_data !== e) begin
                        errors++;
                        $display("FAIL stdout_strobe: got %h expected %h", out_data, e);
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [2:0] op, input logic [31:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        cyc();
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_arg   = '0;
    endtask

    task automatic put_word(input logic [5:0] a, input logic [31:0] d);
        wq.push_back({a, d});
        ld_valid = 1'b1;
        ld_data  = d;
        cyc();
        ld_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; cmd_valid = 0; cmd_op = 0; cmd_arg = 0;
        ld_valid = 0; ld_data = 0; core_pc = 0; core_stdout = 0;
        repeat (3) cyc();
        #2;
        checks++;
        if ({state, cycles, err, out_valid, out_data, core_reset, ld_ready, cmd_ready, imem_we} !==
            {3'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: state=%0d cycles=%0d err=%b ov=%b od=%h crst=%b ldr=%b cr=%b we=%b",
                     state, cycles, err, out_valid, out_data, core_reset, ld_ready, cmd_ready, imem_we);
        end
        reset = 1'b1;
        cyc();
        mon_en = 1;
        #2;
        checks++;
        if (core_reset !== 1'b0 || state !== 3'd0) begin
            errors++;
            $display("FAIL reset_release: core_reset=%b state=%0d expected 0 and 0", core_reset, state);
        end
    endtask

    task automatic test_load_gap();
        cmd(3'd1, 32'd3);
        #2;
        checks++;
        if ({state, ld_ready, core_reset, core_en} !== {3'd1, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL load_enter: state=%0d ld_ready=%b core_reset=%b core_en=%b", state, ld_ready, core_reset, core_en);
        end
        cyc();
        put_word(6'd0, 32'hAAAA_0001);
        cyc();                                   // one-cycle ld_valid gap
        put_word(6'd1, 32'hBBBB_0002);
        put_word(6'd2, 32'hCCCC_0003);
        #2;
        checks++;
        if (state !== 3'd0 || ld_ready !== 1'b0 || wq.size() != 0) begin
            errors++;
            $display("FAIL load_gap_done: state=%0d ld_ready=%b pending=%0d expected 0 0 0", state, ld_ready, wq.size());
        end
    endtask

    task automatic test_load_clip();
        cmd(3'd1, 32'd100);
        for (int i = 0; i < 70; i++) begin
            if (i < 64) wq.push_back({i[5:0], 32'hC000_0000 + i});
            ld_valid = 1'b1;
            ld_data  = 32'hC000_0000 + i;
            cyc();
        end
        ld_valid = 1'b0;
        #2;
        checks++;
        if (state !== 3'd0 || wq.size() != 0 || imem_waddr !== 6'd63) begin
            errors++;
            $display("FAIL load_clip: state=%0d pending=%0d waddr=%0d expected 0 0 63", state, wq.size(), imem_waddr);
        end
    endtask

    task automatic test_load_abort();
        cmd(3'd1, 32'd100);
        for (int i = 0; i < 10; i++) put_word(i[5:0], 32'hD000_0000 + i);
        cmd(3'd4, 32'd0);
        #2;
        checks++;
        if (state !== 3'd0 || ld_ready !== 1'b0 || wq.size() != 0) begin
            errors++;
            $display("FAIL load_abort: state=%0d ld_ready=%b pending=%0d expected 0 0 0", state, ld_ready, wq.size());
        end
        ld_valid = 1'b1; ld_data = 32'hDEAD_BEEF;  // must not be written
        repeat (3) cyc();
        ld_valid = 1'b0;
    endtask

    task automatic test_breakpoint();
        core_pc = 32'h0;
        cmd(3'd6, 32'h10);
        cmd(3'd2, 32'h0);
        #2;
        checks++;
        if ({state, core_reset, core_en} !== {3'd2, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL run_start: state=%0d core_reset=%b core_en=%b expected 2 1 1", state, core_reset, core_en);
        end
        for (int p = 4; p < 16; p += 4) begin core_pc = p; cyc(); end
        core_pc = 32'h10;
        #2;
        checks++;
        if (core_en !== 1'b0) begin
            errors++;
            $display("FAIL bp_hit_en: core_en=%b expected 0", core_en);
        end
        cyc();
        #2;
        checks++;
        if (state !== 3'd4 || core_en !== 1'b0) begin
            errors++;
            $display("FAIL bp_halt: state=%0d core_en=%b expected 4 0", state, core_en);
        end
        cmd(3'd2, 32'h0);
        #2;
        checks++;
        if (state !== 3'd2 || core_en !== 1'b1) begin
            errors++;
            $display("FAIL bp_resume: state=%0d core_en=%b expected 2 1", state, core_en);
        end
        cyc();
        core_pc = 32'h14;
        cmd_valid = 1'b1; cmd_op = 3'd4;
        #2;
        checks++;
        if (core_en !== 1'b1) begin
            errors++;
            $display("FAIL halt_cmd_cycle: core_en=%b expected 1", core_en);
        end
        cyc();
        cmd_valid = 1'b0; cmd_op = 3'd0;
        #2;
        checks++;
        if (state !== 3'd4 || core_en !== 1'b0) begin
            errors++;
            $display("FAIL halt_cmd: state=%0d core_en=%b expected 4 0", state, core_en);
        end
    endtask

    task automatic test_step();
        logic [31:0] c0;
        int pulses;
        core_pc = 32'h10;                        // breakpoint still armed here
        c0 = cycles;
        pulses = 0;
        for (int s = 0; s < 3; s++) begin
            cmd(3'd3, 32'h0);
            #2;
            if (core_en === 1'b1) pulses++;
            cyc();
            #2;
            if (core_en === 1'b1) pulses++;
            if (state !== 3'd4) pulses += 100;
        end
        checks++;
        if (pulses != 3) begin
            errors++;
            $display("FAIL step_pulses: got %0d expected 3", pulses);
        end
        checks++;
        if (cycles !== c0 + 32'd3) begin
            errors++;
            $display("FAIL step_cycles: got %0d expected %0d", cycles, c0 + 32'd3);
        end
        cmd(3'd7, 32'h0);
    endtask

    task automatic test_stdout();
        logic [31:0] seq [4];
        logic        exp_v [5];
        logic [31:0] exp_d [5];
        seq = '{32'h0, 32'h41, 32'h41, 32'h42};
        exp_v = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_d = '{32'h0, 32'h0, 32'h41, 32'h41, 32'h42};
        oq.push_back(32'h41);
        oq.push_back(32'h42);
        for (int i = 0; i < 5; i++) begin
            if (i < 4) core_stdout = seq[i];
            #2;
            checks++;
            if (out_valid !== exp_v[i] || out_data !== exp_d[i]) begin
                errors++;
                $display("FAIL stdout_seq[%0d]: valid=%b data=%h expected %b %h", i, out_valid, out_data, exp_v[i], exp_d[i]);
            end
            cyc();
        end
        #2;
        checks++;
        if (out_valid !== 1'b0 || oq.size() != 0) begin
            errors++;
            $display("FAIL stdout_tail: valid=%b pending=%0d expected 0 0", out_valid, oq.size());
        end
    endtask

    task automatic test_err_clear();
        core_pc = 32'h20;
        cmd(3'd2, 32'h0);
        cmd(3'd3, 32'h0);
        #2;
        checks++;
        if (err !== 1'b1 || state !== 3'd2) begin
            errors++;
            $display("FAIL step_in_run: err=%b state=%0d expected 1 2", err, state);
        end
        cmd(3'd1, 32'd5);
        #2;
        checks++;
        if (err !== 1'b1 || state !== 3'd2 || ld_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_in_run: err=%b state=%0d ld_ready=%b expected 1 2 0", err, state, ld_ready);
        end
        cmd(3'd5, 32'h0);
        #2;
        checks++;
        if ({state, err, cycles, core_reset, core_en} !== {3'd0, 1'b0, 32'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL clear: state=%0d err=%b cycles=%0d core_reset=%b core_en=%b expected 0 0 0 0 0",
                     state, err, cycles, core_reset, core_en);
        end
        core_stdout = 32'h99;                    // held in reset: no strobe expected
        repeat (3) cyc();
    endtask

    task automatic test_reset_mid_load();
        cmd(3'd1, 32'd8);
        put_word(6'd0, 32'hE000_0000);
        put_word(6'd1, 32'hE000_0001);
        reset = 1'b0;
        cyc();
        ld_valid = 1'b1; ld_data = 32'hBAD0_BAD0;
        #2;
        checks++;
        if ({imem_we, state, ld_ready, core_reset} !== {1'b0, 3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_load: we=%b state=%0d ld_ready=%b core_reset=%b expected 0 0 0 0",
                     imem_we, state, ld_ready, core_reset);
        end
        cyc();
        reset = 1'b1;
        cyc();
        ld_valid = 1'b0;
        cyc();
        #2;
        checks++;
        if (state !== 3'd0 || wq.size() != 0 || oq.size() != 0) begin
            errors++;
            $display("FAIL final_idle: state=%0d wq=%0d oq=%0d expected 0 0 0", state, wq.size(), oq.size());
        end
    endtask

    initial begin
        test_reset();
        test_load_gap();
        test_load_clip();
        test_load_abort();
        test_breakpoint();
        test_step();
        test_stdout();
        test_err_clear();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
